// File: rtl/dsp_i2s_tx_pkg.sv
// Shared audio types for the DSP output path: sample, stereo pair and I2S frame geometry.
package dsp_audio_pkg;

    typedef logic signed [15:0] audio_sample_t;

    typedef struct packed {
        audio_sample_t l;
        audio_sample_t r;
    } stereo_frame_t;

    localparam int I2S_SLOTS_PER_FRAME = 32;

endpackage

// File: rtl/dsp_i2s_tx_if.sv
// Sample handshake between the DSP sample path (master) and the I2S transmitter (slave).
interface dsp_i2s_tx_if;
    import dsp_audio_pkg::*;

    audio_sample_t sample_l;
    audio_sample_t sample_r;
    logic          sample_valid;
    logic          sample_ready;

    modport master (output sample_l, output sample_r, output sample_valid, input  sample_ready);
    modport slave  (input  sample_l, input  sample_r, input  sample_valid, output sample_ready);
endinterface

// File: rtl/dsp_i2s_tx_bclk_gen.sv
// Bit-clock divider: BCLK toggles every BCLK_DIV system clocks; fall_evt marks the clock edge where BCLK falls.
// Latency: first rise at edge BCLK_DIV after reset release. No backpressure.
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic i2s_bclk,
    output logic fall_evt
);
    localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [CNT_W-1:0] div_cnt;
    logic             tc;

    assign tc       = (div_cnt == CNT_W'(BCLK_DIV - 1));
    // Combinational so the sequencer updates on the same edge that BCLK falls.
    assign fall_evt = tc & i2s_bclk;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
        end else if (tc) begin
            div_cnt  <= '0;
            i2s_bclk <= ~i2s_bclk;
        end else begin
            div_cnt  <= div_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/dsp_i2s_tx.sv
// Philips I2S stereo transmitter: one-pair holding buffer, bit-clock divider, 32-slot frame sequencer.
// Latency: left MSB leaves 2*BCLK_DIV clocks after the frame load. Backpressure: sample_ready = buffer empty.
// Option: DSP_I2S_TX_MUTE_ON_UNDERRUN_EN sends a silent frame on underrun instead of repeating the last pair.
module dsp_i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic         clock,
    input  logic         reset,
    dsp_i2s_tx_if.slave  smp,
    output logic         i2s_bclk,
    output logic         i2s_lrclk,
    output logic         i2s_sdata,
    output logic         underrun
);
    import dsp_audio_pkg::*;

    localparam int POS_W = $clog2(I2S_SLOTS_PER_FRAME);

    logic                           fall_evt;
    logic [POS_W-1:0]               pos;
    logic [POS_W-1:0]               pos_nxt;
    logic [POS_W-1:0]               bit_idx;
    logic                           load;
    logic                           xfer;
    logic                           hold_full;
    stereo_frame_t                  hold;
    stereo_frame_t                  frame;
    stereo_frame_t                  incoming;
    logic [I2S_SLOTS_PER_FRAME-1:0] frame_bits;

    i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
        .clock    (clock),
        .reset    (reset),
        .i2s_bclk (i2s_bclk),
        .fall_evt (fall_evt)
    );

    assign smp.sample_ready = !hold_full;
    assign xfer             = smp.sample_valid && !hold_full;
    assign incoming         = {smp.sample_l, smp.sample_r};
    assign frame_bits       = frame;
    assign pos_nxt          = pos + POS_W'(1);
    assign load             = fall_evt && (pos_nxt == '0);
    // Slot p carries frame[32-p]; at p=0 this wraps to bit 0 of the frame still in the register.
    assign bit_idx          = POS_W'(0) - pos_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pos       <= '1;
            hold_full <= 1'b0;
            hold      <= '0;
            frame     <= '0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            // A transfer in the load cycle bypasses the buffer and goes straight to the frame.
            if (xfer && !load) begin
                hold      <= incoming;
                hold_full <= 1'b1;
            end
            if (fall_evt) begin
                pos       <= pos_nxt;
                i2s_lrclk <= pos_nxt[POS_W-1];
                i2s_sdata <= frame_bits[bit_idx];
                if (load) begin
                    if (hold_full) begin
                        frame     <= hold;
                        hold_full <= 1'b0;
                    end else if (smp.sample_valid) begin
                        frame <= incoming;
                    end else begin
                        underrun <= 1'b1;
`ifdef DSP_I2S_TX_MUTE_ON_UNDERRUN_EN
                        frame <= '0;
`else
                        frame <= frame;
`endif
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dsp_i2s_tx.sv
// Directed bench for dsp_i2s_tx at BCLK_DIV = 1, 3 and 255.
module tb_dsp_i2s_tx;
    logic clk = 1'b0;
    logic rst1 = 1'b0, rst3 = 1'b0, rst255 = 1'b0;
    logic bclk1, lr1, sd1, ur1;
    logic bclk3, lr3, sd3, ur3;
    logic bclk255, lr255, sd255, ur255;

    dsp_i2s_tx_if sif1();
    dsp_i2s_tx_if sif3();
    dsp_i2s_tx_if sif255();

    dsp_i2s_tx #(.BCLK_DIV(1)) u1 (.clock(clk), .reset(rst1), .smp(sif1),
        .i2s_bclk(bclk1), .i2s_lrclk(lr1), .i2s_sdata(sd1), .underrun(ur1));
    dsp_i2s_tx #(.BCLK_DIV(3)) u3 (.clock(clk), .reset(rst3), .smp(sif3),
        .i2s_bclk(bclk3), .i2s_lrclk(lr3), .i2s_sdata(sd3), .underrun(ur3));
    dsp_i2s_tx #(.BCLK_DIV(255)) u255 (.clock(clk), .reset(rst255), .smp(sif255),
        .i2s_bclk(bclk255), .i2s_lrclk(lr255), .i2s_sdata(sd255), .underrun(ur255));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Frame capture model for u1: slot p holds frame bit 32-p, slot 0 holds bit 0 of the previous frame.
    logic [4:0]  mpos = 5'd31;
    bit          fell = 0, have = 0, prev_b = 0;
    logic [31:0] cur_d = '0, cur_l = '0;
    logic [31:0] frames_q[$];
    logic [31:0] lr_q[$];
    int          urun_cnt = 0;
    int          cyc = 0;
    int          stamps[$];

    always @(posedge clk) cyc++;

    always begin
        @(posedge clk);
        #1;
        fell = 0;
        if (!rst1) begin
            mpos = 5'd31; have = 0; prev_b = 0;
        end else begin
            if (prev_b && !bclk1) begin
                fell = 1;
                mpos = mpos + 5'd1;
                if (mpos != 5'd0) begin
                    cur_d[32 - int'(mpos)] = sd1;
                    cur_l[32 - int'(mpos)] = lr1;
                end else begin
                    cur_d[0] = sd1;
                    cur_l[0] = lr1;
                    if (have) begin
                        frames_q.push_back(cur_d);
                        lr_q.push_back(cur_l);
                    end
                    have = 1;
                end
            end
            if (ur1) urun_cnt++;
            prev_b = bclk1;
        end
    end

    always @(negedge clk)
        if (rst1 && sif1.sample_valid && sif1.sample_ready) stamps.push_back(cyc);

    function automatic logic [15:0] pl(input int k);
        return 16'h1100 + 16'(k) * 16'h0101;
    endfunction
    function automatic logic [15:0] pr(input int k);
        return ~pl(k);
    endfunction

    task automatic wait_pos(input logic [4:0] p, output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #2;
            if (fell && mpos == p) begin ok = 1; break; end
        end
    endtask

    task automatic pop_frame(output logic [31:0] d, output logic [31:0] l);
        d = 32'hxxxx_xxxx; l = 32'hxxxx_xxxx;
        if (frames_q.size() > 0) begin d = frames_q.pop_front(); l = lr_q.pop_front(); end
    endtask

    task automatic test_reset;
        sif1.sample_valid = 0; sif1.sample_l = '0; sif1.sample_r = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bclk1 !== 1'b0) begin bad++; $display("FAIL reset_bclk got %b want 0", bclk1); end
        total++; if (lr1 !== 1'b0) begin bad++; $display("FAIL reset_lrclk got %b want 0", lr1); end
        total++; if (sd1 !== 1'b0) begin bad++; $display("FAIL reset_sdata got %b want 0", sd1); end
        total++; if (ur1 !== 1'b0) begin bad++; $display("FAIL reset_underrun got %b want 0", ur1); end
        total++; if (sif1.sample_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", sif1.sample_ready); end
    endtask

    task automatic test_basic;
        bit ok; logic [31:0] d, l;
        sif1.sample_l = 16'h8001; sif1.sample_r = 16'h7FFE; sif1.sample_valid = 1;
        #1 rst1 = 1;
        @(posedge clk); #2;
        total++; if (sif1.sample_ready !== 1'b0) begin bad++; $display("FAIL basic_accept got ready=%b want 0", sif1.sample_ready); end
        sif1.sample_valid = 0;
        wait_pos(5'd31, ok);
        total++; if (!ok || urun_cnt !== 0) begin bad++; $display("FAIL basic_underrun got ok=%0d cnt=%0d want 1/0", ok, urun_cnt); end
        sif1.sample_l = pl(0); sif1.sample_r = pr(0); sif1.sample_valid = 1;
        wait_pos(5'd0, ok);
        pop_frame(d, l);
        total++; if (d !== 32'h8001_7FFE) begin bad++; $display("FAIL basic_sdata got %h want 80017ffe", d); end
        total++; if (l !== 32'h0001_FFFE) begin bad++; $display("FAIL basic_lrclk got %h want 0001fffe", l); end
        total++; if (urun_cnt !== 0) begin bad++; $display("FAIL basic_no_underrun got %0d want 0", urun_cnt); end
    endtask

    task automatic test_stream;
        int k; bit xf; logic [31:0] d, l;
        stamps.delete();
        k = 1; sif1.sample_l = pl(k); sif1.sample_r = pr(k);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); xf = sif1.sample_valid && sif1.sample_ready;
            @(posedge clk); #2;
            if (xf) begin k++; sif1.sample_l = pl(k); sif1.sample_r = pr(k); end
        end
        sif1.sample_valid = 0;
        total++; if (stamps.size() !== 4) begin bad++; $display("FAIL stream_xfer_count got %0d want 4", stamps.size()); end
        for (int i = 1; i < stamps.size(); i++) begin
            total++; if (stamps[i] - stamps[i-1] !== 64) begin bad++; $display("FAIL stream_xfer_gap%0d got %0d want 64", i, stamps[i] - stamps[i-1]); end
        end
        for (int j = 0; j < 4; j++) begin
            pop_frame(d, l);
            total++; if (d !== {pl(j), pr(j)}) begin bad++; $display("FAIL stream_frame%0d got %h want %h", j, d, {pl(j), pr(j)}); end
            total++; if (l !== 32'h0001_FFFE) begin bad++; $display("FAIL stream_lr%0d got %h want 0001fffe", j, l); end
        end
        total++; if (urun_cnt !== 0) begin bad++; $display("FAIL stream_underrun got %0d want 0", urun_cnt); end
    endtask

    task automatic test_bypass;
        bit ok; int u0; logic [31:0] d, l;
        wait_pos(5'd31, ok);
        u0 = urun_cnt;
        @(posedge clk); #2;
        sif1.sample_l = 16'h1234; sif1.sample_r = 16'h5678; sif1.sample_valid = 1;
        @(posedge clk); #2;
        sif1.sample_valid = 0;
        total++; if (!ok || sif1.sample_ready !== 1'b1) begin bad++; $display("FAIL bypass_ready got ok=%0d ready=%b want 1/1", ok, sif1.sample_ready); end
        total++; if (urun_cnt !== u0) begin bad++; $display("FAIL bypass_underrun got %0d want %0d", urun_cnt, u0); end
        pop_frame(d, l);
        total++; if (d !== {pl(4), pr(4)}) begin bad++; $display("FAIL bypass_prev_frame got %h want %h", d, {pl(4), pr(4)}); end
    endtask

    task automatic test_starve;
        bit ok; int u0; logic [31:0] d, l, want;
        wait_pos(5'd31, ok);
        u0 = urun_cnt;
        wait_pos(5'd0, ok);
        pop_frame(d, l);
        total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL bypass_frame got %h want 12345678", d); end
        total++; if (!ok || urun_cnt !== u0 + 1) begin bad++; $display("FAIL starve_pulse got %0d want %0d", urun_cnt, u0 + 1); end
        @(posedge clk); #2;
        total++; if (ur1 !== 1'b0) begin bad++; $display("FAIL starve_pulse_width got %b want 0", ur1); end
        wait_pos(5'd0, ok);
        pop_frame(d, l);
`ifdef DSP_I2S_TX_MUTE_ON_UNDERRUN_EN
        want = 32'h0000_0000;
`else
        want = 32'h1234_5678;
`endif
        total++; if (d !== want) begin bad++; $display("FAIL starve_frame got %h want %h", d, want); end
    endtask

    task automatic test_mid_reset;
        int rise_at;
        sif3.sample_l = 16'hFFFF; sif3.sample_r = 16'hFFFF; sif3.sample_valid = 1;
        @(posedge clk); #2 rst3 = 1;
        repeat (129) @(posedge clk);
        #2;
        total++; if ({bclk3, lr3, sd3} !== 3'b111) begin bad++; $display("FAIL midrst_before got %b want 111", {bclk3, lr3, sd3}); end
        rst3 = 0;
        #1;
        total++; if ({bclk3, lr3, sd3, ur3} !== 4'b0000) begin bad++; $display("FAIL midrst_outputs got %b want 0000", {bclk3, lr3, sd3, ur3}); end
        total++; if (sif3.sample_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got %b want 1", sif3.sample_ready); end
        #2 rst3 = 1;
        rise_at = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (bclk3) begin rise_at = e; break; end
        end
        total++; if (rise_at !== 3) begin bad++; $display("FAIL midrst_first_rise got %0d want 3", rise_at); end
    endtask

    task automatic test_div255;
        int e, rise_at, fall_at, frame_len;
        bit prev_lr, seen;
        sif255.sample_l = 16'h0F0F; sif255.sample_r = 16'hF0F0; sif255.sample_valid = 1;
        @(posedge clk); #2 rst255 = 1;
        rise_at = -1; fall_at = -1;
        for (e = 1; e <= 2000; e++) begin
            @(posedge clk); #1;
            if (rise_at < 0 && bclk255) rise_at = e;
            else if (rise_at >= 0 && !bclk255) begin fall_at = e; break; end
        end
        total++; if (rise_at !== 255) begin bad++; $display("FAIL div255_first_rise got %0d want 255", rise_at); end
        total++; if (fall_at - rise_at !== 255) begin bad++; $display("FAIL div255_half_period got %0d want 255", fall_at - rise_at); end
        prev_lr = lr255; seen = 0; frame_len = -1; e = 0;
        for (int i = 0; i < 40000; i++) begin
            @(posedge clk); #1;
            e++;
            if (prev_lr && !lr255) begin
                if (seen) begin frame_len = e; break; end
                seen = 1; e = 0;
            end
            prev_lr = lr255;
        end
        total++; if (frame_len !== 16320) begin bad++; $display("FAIL div255_frame got %0d want 16320", frame_len); end
    endtask

    initial begin
        sif3.sample_valid = 0; sif3.sample_l = '0; sif3.sample_r = '0;
        sif255.sample_valid = 0; sif255.sample_l = '0; sif255.sample_r = '0;
        test_reset();
        test_basic();
        test_stream();
        test_bypass();
        test_starve();
        test_mid_reset();
        test_div255();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dsp_i2s_tx.md
# dsp_i2s_tx

Serial audio transmitter for the DSP's stereo output. Accepts one signed 16-bit left/right sample pair per handshake from the DSP sample path (`dac_out_l`/`dac_out_r` qualified by the DSP's audio-valid strobe) and serializes it as a standard Philips I2S stream (32 bit-clocks per frame, MSB one BCLK after the LRCLK edge) toward an external DAC. It sits between the DSP core and the board pins and contains a one-pair holding buffer, the bit-clock divider and the frame sequencer.

## Interface

- `BCLK_DIV`, default 4: system clocks per BCLK half-period; legal range is 1 to 255.
- `clock  in  1`: system clock; all logic runs on its rising edge.
- `reset  in  1`: asynchronous, active-low reset.
- `sample_l  in  16`: signed left sample.
- `sample_r  in  16`: signed right sample.
- `sample_valid  in  1`: the sample pair is presented.
- `sample_ready  out  1`: the holding buffer is empty; a transfer occurs when `sample_valid && sample_ready`.
- `i2s_bclk  out  1`: bit clock.
- `i2s_lrclk  out  1`: word select; 0 means left, 1 means right.
- `i2s_sdata  out  1`: serial data.
- `underrun  out  1`: one-cycle pulse on a frame load that had no sample available.

## Operation

- Divider `div_cnt` counts 0 to `BCLK_DIV-1`. At terminal count it wraps to 0 and toggles `i2s_bclk`. A toggle 1→0 is a falling event; all serial outputs update only on falling events.
- Frame position `pos` is 5 bits and increments by 1, with wrap, on each falling event. Stereo frames run back to back with no gaps.
- On the falling event where `pos` becomes 0, the frame load occurs:
  - The shift register is loaded with `{hold_l, hold_r}` (32 bits) and the holding buffer is emptied.
  - Bypass: if the buffer is empty and a transfer occurs in this same cycle, the incoming pair loads directly into the shift register. This counts as on time.
  - If neither source has a pair, `underrun` pulses for one cycle and the load follows the underrun policy in Configuration.
- Output at falling event entering position p:
  - `i2s_lrclk` is 1 for p from 16 to 31, and 0 otherwise.
  - `i2s_sdata` is the previous frame's right-channel bit 0 when p = 0.
  - Otherwise `i2s_sdata` is `frame[32-p]`, with `frame[31:16]` = left and `frame[15:0]` = right, so MSB-first with a one-bit delay.
- `sample_ready` is `!hold_full`. A transfer sets `hold_full`. A `sample_valid` while full is ignored, and the source must hold it.
- No arithmetic is performed on samples; bits are passed through unchanged as two's complement.

## Timing

- Reset values: `i2s_bclk`=0, `i2s_lrclk`=0, `i2s_sdata`=0, `underrun`=0, `div_cnt`=0, `pos`=31, `hold_full`=0, shift register = 0, so `sample_ready`=1.
- After reset deassertion:
  - First rising BCLK edge is at clock edge `BCLK_DIV`.
  - First falling event is at clock edge `2*BCLK_DIV`; this is the first frame load (`pos`→0).
- Frame period is `64*BCLK_DIV` clocks. At most one pair is consumed per frame.
- Latency: a pair accepted before a load event appears with its left MSB on `i2s_sdata` at the next falling event after the load, i.e. `2*BCLK_DIV` clocks after the load.
- `sample_ready` rises on the clock edge of the load event, combinationally from `hold_full`.
- Reset asserted mid-frame forces all reset values immediately. A partially shifted frame is discarded.

## Configuration

- `DSP_I2S_TX_MUTE_ON_UNDERRUN_EN` defined: an underrun load puts 32'h0 into the shift register, so a silent frame is sent.
- Not defined: an underrun load reloads the last transmitted pair, so the previous sample repeats.
- `underrun` pulses identically in both builds.

## Structure

- Shared package `dsp_audio_pkg` holds:
  - `audio_sample_t` (signed 16-bit),
  - `stereo_frame_t` (struct l/r),
  - `I2S_SLOTS_PER_FRAME` = 32.
- One sub-module, `i2s_bclk_gen`, contains `div_cnt`, `i2s_bclk` and the one-cycle `fall_evt` strobe. The frame sequencer, holding buffer and shift register stay in the top module.

## Test plan

- Reset, then with `BCLK_DIV`=1, load L=16'h8001 and R=16'h7FFE before the first load.
  - Required: `i2s_lrclk` low for 16 BCLKs, then high for 16.
  - Required: sdata bits after the one-bit delay read 1000…0001 then 0111…1110, and `underrun` stays 0.
- Hold `sample_valid` continuously with an incrementing pattern.
  - Required: exactly one transfer per `64*BCLK_DIV` clocks, and every pair transmitted once in order.
- Assert `sample_valid` only in the exact load cycle with an empty buffer.
  - Required: the bypass path transmits that pair and no `underrun` pulse occurs.
- Starve the source for one frame after L=16'h1234, R=16'h5678.
  - Required: `underrun` pulses once.
  - Required with the macro defined: the frame is all zeros.
  - Required without the macro: 16'h1234 and 16'h5678 repeat.
- Assert `reset` at `pos`=20 with `BCLK_DIV`=3.
  - Required: all outputs return to reset values immediately.
  - Required: the first BCLK rise is 3 clocks after release.
- With `BCLK_DIV`=255, the BCLK half-period measures 255 clocks and the frame measures 16320 clocks.
